// File: rtl/booth_result_fifo.sv
// booth_result_fifo: capture stage behind the 4-bit Booth multiplier.
// Each rising edge of `finished` pushes the 8-bit two's-complement product {A,Q}
// into a small FIFO. The consumer drains it over a valid/ready handshake.
// Optional feature macro: BOOTH_SIGNMAG_EN adds the sign/magnitude view of the head entry.
module booth_result_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         aReg,
  input  logic [3:0]         qReg,
  input  logic               finished,
  input  logic               outReady,
  output logic               outValid,
  output logic signed [7:0]  product,
  output logic               prodNeg,
  output logic [7:0]         prodMag,
  output logic [PTR_W:0]     count,
  output logic               full,
  output logic               dropped
);

  logic                fin_prev;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      cnt;
  logic                dropped_r;
  logic signed [7:0]   mem [DEPTH];

  logic fin_evt;
  logic pop;
  logic push;
  logic lost;

`ifdef BOOTH_SIGNMAG_EN
  // Magnitude of a signed product; the Booth range never reaches -128.
  function automatic logic [7:0] signed_to_mag(input logic signed [7:0] v);
    logic signed [7:0] neg_v;
    neg_v = -v;
    return v[7] ? neg_v : v;
  endfunction
`endif

  // One event per completion: only the rising edge of the level flag counts.
  assign fin_evt = finished & ~fin_prev;
  assign pop     = outValid & outReady;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push    = fin_evt & (~full | pop);
  assign lost    = fin_evt & full & ~pop;

  assign full     = (cnt == (PTR_W+1)'(DEPTH));
  assign outValid = (cnt != '0);
  assign count    = cnt;
  assign dropped  = dropped_r;
  assign product  = mem[rd_ptr];

`ifdef BOOTH_SIGNMAG_EN
  assign prodNeg = product[7];
  assign prodMag = signed_to_mag(product);
`else
  assign prodNeg = 1'b0;
  assign prodMag = product;
`endif

  // Control state: edge detector, pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fin_prev  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      dropped_r <= 1'b0;
    end else begin
      fin_prev <= finished;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      cnt <= cnt + (PTR_W+1)'(1);
      else if (pop && !push) cnt <= cnt - (PTR_W+1)'(1);
      if (lost) dropped_r <= 1'b1;
    end
  end

  // Storage: data is not reset; an event during reset is ignored.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {aReg, qReg};
  end

endmodule

// File: tb/tb_booth_result_fifo.sv
// Self-checking bench for booth_result_fifo: directed test-plan steps followed
// by randomized traffic, all compared against a queue-based reference model.
module tb_booth_result_fifo;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        aReg;
  logic [3:0]        qReg;
  logic              finished;
  logic              outReady;
  logic              outValid;
  logic [7:0]        product;
  logic              prodNeg;
  logic [7:0]        prodMag;
  logic [PTR_W:0]    count;
  logic              full;
  logic              dropped;

  booth_result_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .aReg(aReg), .qReg(qReg), .finished(finished),
    .outReady(outReady), .outValid(outValid), .product(product),
    .prodNeg(prodNeg), .prodMag(prodMag), .count(count), .full(full),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state.
  logic [7:0] qm[$];
  logic       prev_m;
  logic       drop_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int signed v;
    chk({tag, ".outValid"}, 32'(outValid), 32'(qm.size() != 0));
    chk({tag, ".count"},    32'(count),    32'(qm.size()));
    chk({tag, ".full"},     32'(full),     32'(qm.size() == DEPTH));
    chk({tag, ".dropped"},  32'(dropped),  32'(drop_m));
    if (qm.size() != 0) begin
      chk({tag, ".product"}, 32'(product), 32'(qm[0]));
      v = $signed(qm[0]);
`ifdef BOOTH_SIGNMAG_EN
      chk({tag, ".prodNeg"}, 32'(prodNeg), 32'(v < 0));
      chk({tag, ".prodMag"}, 32'(prodMag), 32'((v < 0) ? -v : v));
`else
      chk({tag, ".prodNeg"}, 32'(prodNeg), 32'(0));
      chk({tag, ".prodMag"}, 32'(prodMag), 32'(qm[0]));
`endif
    end
  endtask

  // Drive one cycle of inputs, advance the model, clock the DUT, then compare.
  task automatic step(input string tag, input logic f, input logic [3:0] a,
                      input logic [3:0] q, input logic rdy, input logic r);
    logic ev;
    logic pp;
    rst = r; finished = f; aReg = a; qReg = q; outReady = rdy;
    if (r) begin
      qm.delete();
      prev_m = 1'b0;
      drop_m = 1'b0;
    end else begin
      ev = f && !prev_m;
      pp = (qm.size() != 0) && rdy;
      if (pp) void'(qm.pop_front());
      if (ev) begin
        if (qm.size() < DEPTH) qm.push_back({a, q});
        else drop_m = 1'b1;
      end
      prev_m = f;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic event_push(input string tag, input logic [3:0] a, input logic [3:0] q,
                            input logic rdy);
    step(tag, 1'b0, a, q, 1'b0, 1'b0);
    step(tag, 1'b1, a, q, rdy, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1; i++) step(tag, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
  endtask

  initial begin
    qm.delete();
    prev_m = 1'b0;
    drop_m = 1'b0;
    rst = 1'b1; finished = 1'b0; aReg = '0; qReg = '0; outReady = 1'b0;

    // Reset state
    step("reset", 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    step("reset", 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("reset_count_const", 32'(count), 32'(0));

    // Single event 3 x -2, visible one edge after finished rises
    step("evt_fa", 1'b1, 4'hF, 4'hA, 1'b0, 1'b0);
    chk("evt_fa_const", 32'(product), 32'hFA);
`ifdef BOOTH_SIGNMAG_EN
    chk("evt_fa_mag_const", 32'(prodMag), 32'h06);
`endif
    // Held finished never re-captures
    for (int i = 0; i < 20; i++) step("hold", 1'b1, 4'h3, 4'h3, 1'b0, 1'b0);
    chk("hold_count_const", 32'(count), 32'(1));
    step("pop_one", 1'b1, 4'h3, 4'h3, 1'b1, 1'b0);
    step("ready_empty", 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);

    // Fill, overflow, drain in order
    event_push("fill", 4'h4, 4'h0, 1'b0);
    event_push("fill", 4'h0, 4'h0, 1'b0);
    event_push("fill", 4'hC, 4'h8, 1'b0);
    event_push("fill", 4'h1, 4'h5, 1'b0);
    event_push("overflow", 4'h7, 4'h7, 1'b0);
    chk("overflow_dropped_const", 32'(dropped), 32'(1));
    drain("drain1");

    // Full + event + pop in the same cycle
    step("reset2", 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    event_push("fill2", 4'h4, 4'h0, 1'b0);
    event_push("fill2", 4'h0, 4'h0, 1'b0);
    event_push("fill2", 4'hC, 4'h8, 1'b0);
    event_push("fill2", 4'h1, 4'h5, 1'b0);
    event_push("full_push_pop", 4'h2, 4'h3, 1'b1);
    chk("full_push_pop_count_const", 32'(count), 32'(4));
    drain("drain2");

    // Pointer wrap with interleaved pops
    for (int i = 0; i < 6; i++) begin
      event_push("wrap", 4'(i + 1), 4'(i * 3), 1'b0);
      if (i % 2 == 1) step("wrap_pop", 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    end
    drain("drain3");

    // Reset mid-stream with a coincident event
    event_push("pre_rst", 4'h1, 4'h1, 1'b0);
    event_push("pre_rst", 4'h2, 4'h2, 1'b0);
    event_push("pre_rst", 4'h3, 4'h3, 1'b0);
    step("pre_rst", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    step("rst_evt", 1'b1, 4'h9, 4'h9, 1'b0, 1'b1);
    chk("rst_evt_count_const", 32'(count), 32'(0));
    // finished still high as reset releases: captures once
    step("post_rst", 1'b1, 4'h6, 4'h1, 1'b0, 1'b0);
    step("post_rst_hold", 1'b1, 4'h6, 4'h1, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 199) == 0));
    end
    drain("drain_rand");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/booth_result_fifo.md
# booth_result_fifo

Downstream capture stage for the 4-bit Booth multiplier. It watches the datapath's A and Q registers and the controller's `finished` flag. On each new completion it captures the 8-bit two's-complement product {A,Q} into a small FIFO. Results are delivered to the consumer over a valid/ready handshake, so multiplications can complete back-to-back without the consumer keeping pace.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `PTR_W`, 2: log2(`DEPTH`).

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `aReg` in 4: multiplier A register, upper product half.
- `qReg` in 4: multiplier Q register, lower product half.
- `finished` in 1: controller done flag; level, stays high while the controller sits in END.
- `outReady` in 1: consumer accepts the head entry this cycle.
- `outValid` out 1: head entry valid.
- `product` out 8: head entry, two's complement, {A,Q}.
- `prodNeg` out 1: head entry sign (see Configuration).
- `prodMag` out 8: head entry magnitude (see Configuration).
- `count` out `PTR_W`+1: entries held, 0..`DEPTH`.
- `full` out 1: `count` == `DEPTH`.
- `dropped` out 1: sticky; a completion was lost because the FIFO was full.

## Operation
- Edge detect:
  - `finPrev` register samples `finished` every cycle.
  - A capture event is `finished & ~finPrev`.
  - One event per multiplication; holding `finished` high never re-captures.
  - Deassertion of `finished` (controller restarted) followed by re-assertion produces a new event.
- Push:
  - On an event with `full`=0, write {`aReg`,`qReg`} to `mem[wrPtr]` and increment `wrPtr` (mod `DEPTH`).
  - On an event with `full`=1, discard the data and set `dropped`=1. `dropped` clears only on `rst`.
- Pop:
  - Occurs when `outValid & outReady`. Increment `rdPtr` (mod `DEPTH`).
  - `outReady` while `outValid`=0 has no effect.
- Count:
  - Push only: +1. Pop only: −1. Push and pop together: unchanged, and both pointers advance.
  - Push and pop together while full: the push is accepted because the pop frees a slot in the same edge, and `dropped` is not set.
  - Push and pop together while empty: cannot occur, since `outValid`=0.
- Outputs:
  - `outValid` = (`count` != 0).
  - `product` = `mem[rdPtr]`, combinational read of registered storage.
  - Head data is stable while `outValid`=1 and `outReady`=0.
- Arithmetic:
  - `product` is signed 8-bit.
  - The valid Booth 4×4 range is −56..+64, so no overflow handling is needed.
- Reset:
  - `wrPtr`, `rdPtr`, `count`, `finPrev`, and `dropped` go to 0.
  - Memory contents are don't-care.
  - A reset asserted mid-stream discards all entries; an event in the same cycle as `rst` is ignored.
  - Because `finPrev` resets to 0, a `finished` already high when `rst` deasserts captures once on the first post-reset edge.
- Reset values of outputs: `outValid`=0, `count`=0, `full`=0, `dropped`=0. `product`, `prodNeg`, and `prodMag` are don't-care while `outValid`=0.

## Timing
- `finished` rises between edges k−1 and k. The entry is written at edge k, and `outValid`=1 from edge k.
- Latency is one edge from the first high sample of `finished` to valid output.
- Pop at edge j: the next entry appears at `product` immediately after edge j, or `outValid` drops to 0.
- Sustained throughput is one push and one pop per cycle. The multiplier produces at most one result per ~14 cycles.
- The controller updates on negedge. `aReg`/`qReg` are final before `finished` rises, so sampling them at the posedge is safe.

## Configuration
- `BOOTH_SIGNMAG_EN` defined:
  - `prodNeg` = `product[7]`.
  - `prodMag` = `product[7]` ? −`product` : `product` (8-bit; +64 → 0x40, −56 → 0x38).
  - This logic is combinational on the head entry.
- `BOOTH_SIGNMAG_EN` undefined:
  - `prodNeg` tied 0, `prodMag` tied to `product`.
  - No negation logic is synthesized.

## Test plan
- Reset, then event with A=0xF, Q=0xA (3×−2) → at the next edge `outValid`=1, `product`=0xFA, `count`=1. With the macro defined, `prodNeg`=1 and `prodMag`=0x06.
- `finished` held high for 20 cycles after one rise → exactly one entry, `count`=1. Pop with `outReady`=1 → `outValid`=0.
- Four events with `outReady`=0 (products 0x40, 0x00, 0xC8, 0x15) → `full`=1. A fifth event → `dropped`=1 and `count` stays 4. Draining returns 0x40, 0x00, 0xC8, 0x15 in order.
- With the FIFO full, an event and a pop in the same cycle → `count` stays 4, `dropped` stays 0, and the new entry appears last on drain.
- Write 6 entries while interleaving pops so the pointers wrap → output order matches input order and `count` never exceeds 4.
- `rst` asserted with 3 entries held and an event in the same cycle → `count`=0, `outValid`=0, `dropped`=0 after the edge.
